// File: rtl/ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// ssd_scan_driver
//   Time-multiplexed driver for a bank of NUM_DIGITS seven-segment digits.
//   One digit is lit per refresh slot of PRESCALE clocks. The displayed
//   value comes from a shadow register that is only updated at a frame
//   boundary, so a scan never shows a mix of old and new digits. Supports
//   per-digit decimal point, leading-zero blanking and per-digit blink.
//
// Ports
//   clk        : system clock
//   rst_n      : synchronous, active-low reset
//   enable     : scan enable; when low, counters hold and outputs go dark
//   value      : packed hex digits, digit i = value[4i+3:4i], digit 0 rightmost
//   load       : request to capture value into the shadow at the next frame
//   dp_mask    : per-digit decimal point enable
//   blank_lz   : suppress leading zeros (digit 0 is always shown)
//   blink_mask : digits that blink with the blink phase
//   segment    : {a,b,c,d,e,f,g}, bit 6 = a
//   dp         : decimal point
//   anode      : one-hot digit select
//   frame_done : one-cycle pulse after the last digit slot of each scan
// ---------------------------------------------------------------------------
module ssd_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE       = 50000,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              segment,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_done
);

    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BL_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK_FRAMES - 1);

    // Active-high hex to seven-segment decode, bit 6 = a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1110011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b1001110;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            default: seg = 7'b1000111;
        endcase
        return seg;
    endfunction

    logic [PS_W-1:0]         ps_cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    load_pending;
    logic [BL_W-1:0]         blink_cnt;
    logic                    blink_phase;

    logic                    slot_tc;
    logic                    frame_wrap;
    logic [3:0]              cur_nib;
    logic                    lz_blank;
    logic                    blink_off;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [6:0]              seg_p0;
    logic                    dp_p0;

    logic [6:0]              seg_p1;
    logic                    dp_p1;
    logic [NUM_DIGITS-1:0]   anode_p1;
    logic                    vld_p1;

    assign slot_tc    = enable && (ps_cnt == PS_LAST);
    assign frame_wrap = slot_tc && (idx == IDX_LAST);

    // ---- control: prescaler, digit index, shadow load, blink ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ps_cnt       <= '0;
            idx          <= '0;
            shadow       <= '0;
            load_pending <= 1'b0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
        end else begin
            if (enable) begin
                ps_cnt <= slot_tc ? '0 : ps_cnt + 1'b1;
            end
            if (slot_tc) begin
                idx <= frame_wrap ? '0 : idx + 1'b1;
            end
            // A load arriving on the boundary cycle is honoured immediately;
            // any earlier loads in the frame just keep the request pending.
            if (frame_wrap) begin
                if (load_pending || load) begin
                    shadow <= value;
                end
                load_pending <= 1'b0;
            end else if (load) begin
                load_pending <= 1'b1;
            end
            if (frame_wrap) begin
                if (blink_cnt == BL_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // ---- p0: digit decode for the current index ----
    always_comb begin
        cur_nib  = shadow[4*int'(idx) +: 4];
        onehot   = NUM_DIGITS'(1) << idx;
        // A digit is a leading zero when it and every digit above it are 0.
        lz_blank = 1'b0;
        if (blank_lz && (idx != '0)) begin
            lz_blank = 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if ((i >= int'(idx)) && (shadow[4*i +: 4] != 4'h0)) begin
                    lz_blank = 1'b0;
                end
            end
        end
        blink_off = blink_phase && blink_mask[idx];
        seg_p0    = (lz_blank || blink_off) ? 7'b0000000 : hex_to_seg(cur_nib);
        dp_p0     = dp_mask[idx] && !blink_off;
    end

    // ---- p1: registered outputs, polarity applied here only ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_p1     <= '0;
            dp_p1      <= 1'b0;
            anode_p1   <= '0;
            vld_p1     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            vld_p1     <= enable;
            seg_p1     <= enable ? seg_p0 : '0;
            dp_p1      <= enable && dp_p0;
            anode_p1   <= enable ? onehot : '0;
            frame_done <= frame_wrap;
        end
    end

    assign segment = seg_p1 ^ {7{SEG_ACTIVE_LOW}};
    assign dp      = dp_p1 ^ SEG_ACTIVE_LOW;
    assign anode   = (vld_p1 ? anode_p1 : '0) ^ {NUM_DIGITS{AN_ACTIVE_LOW}};

endmodule

// File: tb/tb_ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_driver
//   Self-checking bench for ssd_scan_driver with NUM_DIGITS=4, PRESCALE=4,
//   BLINK_FRAMES=2 and default polarities (segments active-high, anodes
//   active-low). A reference model tracks the position inside the frame, the
//   number of completed frames and the shadow value, and derives every
//   expected output from those.
// ---------------------------------------------------------------------------
module tb_ssd_scan_driver;

    localparam int ND = 4;
    localparam int P  = 4;
    localparam int BF = 2;
    localparam int F  = ND * P;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [15:0]   value;
    logic          load;
    logic [3:0]    dp_mask;
    logic          blank_lz;
    logic [3:0]    blink_mask;
    logic [6:0]    segment;
    logic          dp;
    logic [3:0]    anode;
    logic          frame_done;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          m_pos;
    int          m_frames;
    logic [15:0] m_shadow;
    bit          m_pending;

    logic [6:0] seg_table [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    ssd_scan_driver #(
        .NUM_DIGITS    (ND),
        .PRESCALE      (P),
        .BLINK_FRAMES  (BF),
        .SEG_ACTIVE_LOW(1'b0),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .value     (value),
        .load      (load),
        .dp_mask   (dp_mask),
        .blank_lz  (blank_lz),
        .blink_mask(blink_mask),
        .segment   (segment),
        .dp        (dp),
        .anode     (anode),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict outputs from the model and current inputs, advance
    // the model, then compare after the edge.
    task automatic tick();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_fd;
        logic [3:0] nib;
        bit         lz;
        bit         bl;
        int         d;
        e_an  = 4'b1111;
        e_seg = 7'b0;
        e_dp  = 1'b0;
        e_fd  = 1'b0;
        if (!rst_n) begin
            m_pos     = 0;
            m_frames  = 0;
            m_shadow  = '0;
            m_pending = 0;
        end else begin
            d   = m_pos / P;
            nib = 4'(m_shadow >> (4 * d));
            lz  = blank_lz && (d != 0) && ((m_shadow >> (4 * d)) == 16'h0);
            bl  = (((m_frames / BF) % 2) == 1) && blink_mask[d];
            if (enable) begin
                e_an  = ~(4'b0001 << d);
                e_seg = (lz || bl) ? 7'b0 : seg_table[nib];
                e_dp  = dp_mask[d] && !bl;
            end
            e_fd = enable && (m_pos == F - 1);
            if (e_fd) begin
                m_frames++;
                if (m_pending || load) m_shadow = value;
                m_pending = 0;
            end else if (load) begin
                m_pending = 1;
            end
            if (enable) m_pos = (m_pos + 1) % F;
        end
        @(posedge clk);
        #1;
        check("anode", 32'(anode), 32'(e_an));
        check("segment", 32'(segment), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until digit d is lit, bounded; a timeout shows up as a failed
    // anode comparison.
    task automatic wait_digit(input int d);
        logic [3:0] want;
        int n;
        want = ~(4'b0001 << d);
        n = 0;
        tick();
        while (anode !== want && n < 64) begin
            tick();
            n++;
        end
        check("wait_digit", 32'(anode), 32'(want));
    endtask

    initial begin
        int fd_count;
        rst_n      = 1'b0;
        enable     = 1'b0;
        value      = 16'h0;
        load       = 1'b0;
        dp_mask    = 4'b0;
        blank_lz   = 1'b0;
        blink_mask = 4'b0;
        m_pos = 0; m_frames = 0; m_shadow = '0; m_pending = 0;

        // Reset state
        run(2);
        check("rst_anode", 32'(anode), 32'h0000000F);
        check("rst_segment", 32'(segment), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);

        // Plain scanning, frame_done every 16 clocks
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();
        check("first_slot", 32'(anode), 32'h0000000E);
        run(20);
        fd_count = 0;
        for (int i = 0; i < 2 * F; i++) begin
            tick();
            if (frame_done === 1'b1) fd_count++;
        end
        check("frame_done_rate", 32'(fd_count), 32'd2);

        // Mid-frame load of 12A0
        run(5);
        value = 16'h12A0;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        run(2 * F);
        wait_digit(1);
        check("digit1_A", 32'(segment), 32'h77);
        wait_digit(3);
        check("digit3_1", 32'(segment), 32'h30);

        // Leading-zero blanking
        value    = 16'h0050;
        blank_lz = 1'b1;
        load     = 1'b1;
        tick();
        load = 1'b0;
        run(2 * F);
        wait_digit(3);
        check("lz_digit3", 32'(segment), 32'h0);
        wait_digit(2);
        check("lz_digit2", 32'(segment), 32'h0);
        wait_digit(1);
        check("lz_digit1", 32'(segment), 32'h5B);
        wait_digit(0);
        check("lz_digit0", 32'(segment), 32'h7E);
        value = 16'h0000;
        load  = 1'b1;
        tick();
        load = 1'b0;
        run(2 * F);
        wait_digit(0);
        check("zero_digit0", 32'(segment), 32'h7E);

        // Blink of digit 0 with its decimal point
        blank_lz   = 1'b0;
        blink_mask = 4'b0001;
        dp_mask    = 4'b0001;
        run(10 * F);

        // Enable gap mid-slot
        run(6);
        enable = 1'b0;
        tick();
        check("gap_anode", 32'(anode), 32'h0000000F);
        run(9);
        enable = 1'b1;
        run(2 * F);

        // Reset mid-frame with a load pending
        run(3);
        value = 16'hBEEF;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        rst_n = 1'b0;
        tick();
        check("midrst_anode", 32'(anode), 32'h0000000F);
        rst_n = 1'b1;
        run(3 * F);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 299) != 0);
            enable     = ($urandom_range(0, 9) != 0);
            load       = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) value = 16'($urandom);
            if ($urandom_range(0, 49) == 0) dp_mask = 4'($urandom);
            if ($urandom_range(0, 49) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(0, 49) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(0, 3) == 0) value = 16'($urandom_range(0, 255));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Parametrised, time-multiplexed driver for a bank of common-anode/cathode 7-segment digits.
- Successor to the single-digit hex decoder.
- Takes a packed hex word and scans one digit per refresh slot, with per-digit decimal point, leading-zero blanking, per-digit blink and tear-free value loading.
- Sits between the game datapath and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- PRESCALE, 50000, clk cycles per digit slot (>=2).
- BLINK_FRAMES, 64, frames per blink half-period (>=1).
- SEG_ACTIVE_LOW, 0, 1 inverts segment and dp outputs.
- AN_ACTIVE_LOW, 1, 1 inverts anode outputs.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  scan enable.
- value  in  4*NUM_DIGITS  packed hex digits; digit i = value[4i+3:4i]; digit 0 is rightmost.
- load  in  1  request to capture value into the shadow register.
- dp_mask  in  NUM_DIGITS  decimal point on per digit.
- blank_lz  in  1  suppress leading zeros.
- blink_mask  in  NUM_DIGITS  digits that blink.
- segment  out  7  segments {a,b,c,d,e,f,g}, bit6=a.
- dp  out  1  decimal point.
- anode  out  NUM_DIGITS  one-hot digit select.
- frame_done  out  1  one-cycle pulse at end of each full scan.

Behaviour:
- Reset and polarity:
  - Reset is synchronous and active-low. On clk edge with rst_n=0: prescale count=0, digit index=0, shadow=0, load_pending=0, blink count=0, blink phase=0.
  - All outputs at reset are inactive: segment/dp off, anode all off, frame_done=0. Inactive level follows the polarity parameters, e.g. with defaults anode=all 1, segment=0.
  - Internal logic is active-high; inversion is applied only at the output registers.
- Prescaler:
  - With enable=1, counts 0..PRESCALE-1.
  - At terminal count (tc), the digit index increments, wrapping NUM_DIGITS-1 -> 0.
  - The wrap cycle is the frame boundary: frame_done=1 for exactly one cycle, registered in the cycle after the tc edge.
- Outputs:
  - All outputs are registered and reflect the current index one cycle after it changes.
  - Only the active digit's anode is asserted.
- Decode table, digit -> segment (active-high):
  - 0:1111110, 1:0110000, 2:1101101, 3:1111001, 4:0110011, 5:1011011, 6:1011111, 7:1110000
  - 8:1111111, 9:1110011, A:1110111, b:0011111, C:1001110, d:0111101, E:1001111, F:1000111.
- Shadow load:
  - load=1 sets load_pending. The shadow register captures value at the next frame boundary; that cycle's value is used.
  - If load and the frame boundary coincide, the same-cycle value is captured.
  - Frames are never torn. Multiple loads within one frame collapse to a single capture of the value present at the boundary.
- Leading-zero blanking:
  - With blank_lz=1, digits from index NUM_DIGITS-1 downward whose shadow nibble is 0 blank their segments, until the first nonzero digit.
  - Digit 0 is never LZ-blanked.
  - dp is unaffected by LZ blanking.
- Blink:
  - The blink counter counts frame boundaries. On reaching BLINK_FRAMES-1 it resets and toggles blink phase.
  - While phase=1, digits in blink_mask output segments off and dp off; the anode still strobes.
- enable=0:
  - Prescaler, index and blink counter hold.
  - Outputs go inactive on the next edge; no frame_done.
  - On re-enable, scanning resumes from the held index and count.
- Reset mid-scan or mid-blink returns to the reset state on that edge; pending loads are discarded.

Test Plan:
- NUM_DIGITS=4, PRESCALE=4; release reset, enable=1 -> anode (active-low) cycles 1110,1101,1011,0111, 4 clk each; frame_done pulses every 16 clk, one cycle wide.
- load=1 with value=16'h12A0 mid-frame -> display unchanged until the next frame_done. Next frame shows digits 0,A,2,1 as 1111110,1110111,1101101,0110000.
- value=16'h0050, blank_lz=1 -> digits 3 and 2 have segment=0000000; digit 1 = 1011011; digit 0 = 1111110. With value=0, digit 0 still shows 0.
- BLINK_FRAMES=2, blink_mask=4'b0001, dp_mask=4'b0001 -> digit 0 segments and dp are on for 2 frames and off for 2 frames, alternating; other digits steady.
- enable=0 for 10 clk mid-slot -> anode=1111 and no frame_done during the gap. After re-enable the same digit finishes its remaining slot count.
- rst_n=0 for one edge mid-frame with load_pending set -> all outputs inactive next cycle, index 0, shadow=0; the pending load is not applied.
